biu_bus_cycle_ctrl: RTL and testbench
=====================================

// Module: biu_bus_cycle_ctrl
// PURPOSE
//   Bus-cycle sequencer for the 8086 bus interface unit (BIU).
//   Shares the external memory bus between two requesters: the execution unit (EU) and the prefetch-queue filler (PF).
//   Runs 8086-style T1/T2/T3/Tw/T4 cycles, honours READY wait states, and enforces a wait-state timeout.
//   Address, write data, direction and owner are captured in internal registered stages at grant.
// PARAMETERS
//   ADDR_WIDTH  20  physical address width
//   DATA_WIDTH  16  bus data width
//   MAX_WAIT    15  max consecutive Tw states before the cycle aborts with error (>=1)
// PORTS
//   clk        in   1           clock, all state changes on rising edge
//   reset      in   1           asynchronous, active-high
//   eu_req     in   1           EU requests a bus cycle; hold with addr/we/wdata stable until eu_ack
//   eu_we      in   1           1 = write, 0 = read
//   eu_addr    in   ADDR_WIDTH  EU address
//   eu_wdata   in   DATA_WIDTH  EU write data
//   eu_ack     out  1           1-cycle pulse: EU cycle complete
//   pf_req     in   1           prefetch read request; hold with pf_addr stable until pf_ack
//   pf_addr    in   ADDR_WIDTH  prefetch address
//   pf_ack     out  1           1-cycle pulse: prefetch cycle complete
//   rdata      out  DATA_WIDTH  read data; valid in the eu_ack/pf_ack cycle
//   bus_err    out  1           pulses with the ack when the cycle timed out
//   bus_addr   out  ADDR_WIDTH  latched address, held for T1..T4
//   bus_wdata  out  DATA_WIDTH  latched write data, held for T1..T4
//   bus_rdata  in   DATA_WIDTH  memory read data
//   bus_ale    out  1           address latch enable, high in T1 only
//   bus_rd_n   out  1           read strobe, active low
//   bus_wr_n   out  1           write strobe, active low
//   bus_ready  in   1           memory ready; sampled in T3 and Tw
//   busy       out  1           high in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE. All outputs at reset values:
//     - eu_ack, pf_ack, bus_err, bus_ale, busy = 0
//     - bus_rd_n, bus_wr_n = 1
//     - bus_addr, bus_wdata, rdata = 0
//   Reset mid-cycle: outputs return to reset values immediately (asynchronous). No ack is issued; requesters re-request.
//   States: IDLE, T1, T2, T3, TW, T4.
//     IDLE -> T1 when any request is eligible.
//     T1 -> T2 unconditionally; bus_ale = 1.
//     T2 -> T3 unconditionally; strobe asserts.
//     T3 -> T4 if bus_ready = 1, else -> TW.
//     TW -> T4 if bus_ready = 1 or wait count reaches MAX_WAIT, else stays in TW.
//     T4 -> T1 if an eligible request exists (back-to-back, no idle cycle), else -> IDLE.
//   Arbitration: evaluated in IDLE and in T4.
//     - EU has fixed priority over PF.
//     - A started cycle is never preempted.
//     - In T4, the owner being acked is ineligible that cycle, so a still-high req is not re-granted.
//   Grant: on the IDLE/T4 -> T1 edge, the winner's addr, wdata, we (PF: we=0) and owner are latched.
//     - bus_addr and bus_wdata come from these latches.
//     - Requester inputs are ignored until the next grant.
//   Strobes:
//     - Read: bus_rd_n = 0 in T2, T3, TW.
//     - Write: bus_wr_n = 0 in T2, T3, TW.
//     - Both strobes are 1 in T1, T4 and IDLE; never both low.
//   Read data: bus_rdata is captured on the edge leaving T3/TW with bus_ready = 1.
//     - Presented on rdata during T4.
//     - rdata holds its value until the next capture.
//   Completion: the owner's ack is high for exactly the T4 cycle.
//   Latency (zero waits): grant edge -> ack at the 4th clock (T1, T2, T3, T4). Each Tw adds 1 cycle.
//   Wait counter:
//     - Cleared in T1 and incremented per TW cycle; sized to hold MAX_WAIT.
//     - On reaching MAX_WAIT with bus_ready still 0, go to T4:
//       ack asserts with bus_err = 1, rdata is not updated, and writes are considered lost.
//   Throughput: back-to-back cycles every 4 clocks plus waits.
//   Priority starvation: PF starvation under continuous EU requests is accepted behaviour.
// TESTING
//   1. EU read 0x12345, bus_rdata = 0xBEEF, ready = 1:
//      bus_ale in T1, rd_n low 2 cycles, eu_ack at clk 4, rdata = 0xBEEF, bus_err = 0.
//   2. EU write 0xA5A5 @ 0x00100, ready low 2 cycles:
//      wr_n low 4 cycles (T2, T3, Tw, Tw), bus_wdata = 0xA5A5, eu_ack at clk 6.
//   3. eu_req and pf_req together at IDLE:
//      EU served first; PF T1 immediately follows EU T4; pf_ack 4 clocks after eu_ack.
//   4. pf_req held continuously, eu_req raised during PF T2:
//      PF cycle completes; EU granted at that T4; PF resumes after eu_ack.
//   5. MAX_WAIT = 4, ready held 0:
//      4 Tw cycles, then T4 with eu_ack = 1 and bus_err = 1; rdata unchanged.
//   6. reset asserted during Tw of a read:
//      rd_n = 1, busy = 0 and no ack in the same cycle; after release, a new request completes normally.

Source files
------------

// File: rtl/biu_bus_cycle_ctrl.sv
// 8086 BIU bus-cycle sequencer: T1/T2/T3/Tw/T4 cycles shared between
// the execution unit (priority) and the prefetch filler, with Tw timeout.
module biu_bus_cycle_ctrl #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  eu_req,
    input  logic                  eu_we,
    input  logic [ADDR_WIDTH-1:0] eu_addr,
    input  logic [DATA_WIDTH-1:0] eu_wdata,
    output logic                  eu_ack,
    input  logic                  pf_req,
    input  logic [ADDR_WIDTH-1:0] pf_addr,
    output logic                  pf_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  bus_err,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_ale,
    output logic                  bus_rd_n,
    output logic                  bus_wr_n,
    input  logic                  bus_ready,
    output logic                  busy
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic OWN_PF = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4
    } state_t;

    state_t                  state_q;
    logic [WCW-1:0]          wcnt_q;
    logic                    owner_q;
    logic                    we_q;
    logic                    eu_ack_q, pf_ack_q, err_q, ale_q;
    logic                    rd_n_q, wr_n_q, busy_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;

    logic eu_elig, pf_elig, any_elig, wait_max, done;

    // The owner being acked in T4 may not be re-granted in that same cycle.
    assign eu_elig  = eu_req & ~(state_q == S_T4 && owner_q != OWN_PF);
    assign pf_elig  = pf_req & ~(state_q == S_T4 && owner_q == OWN_PF);
    assign any_elig = eu_elig | pf_elig;
    assign wait_max = (wcnt_q == WCW'(MAX_WAIT - 1));
    assign done     = (state_q == S_T3 && bus_ready) ||
                      (state_q == S_TW && (bus_ready || wait_max));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wcnt_q   <= '0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            eu_ack_q <= 1'b0;
            pf_ack_q <= 1'b0;
            err_q    <= 1'b0;
            ale_q    <= 1'b0;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            eu_ack_q <= 1'b0;
            pf_ack_q <= 1'b0;
            err_q    <= 1'b0;
            ale_q    <= 1'b0;
            case (state_q)
                S_IDLE, S_T4: begin
                    if (any_elig) begin
                        state_q <= S_T1;
                        ale_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        owner_q <= ~eu_elig;
                        we_q    <= eu_elig & eu_we;
                        addr_q  <= eu_elig ? eu_addr : pf_addr;
                        wdata_q <= eu_elig ? eu_wdata : '0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_T1: begin
                    state_q <= S_T2;
                    wcnt_q  <= '0;
                    rd_n_q  <= we_q;
                    wr_n_q  <= ~we_q;
                end
                S_T2: state_q <= S_T3;
                S_T3, S_TW: begin
                    if (done) begin
                        state_q  <= S_T4;
                        rd_n_q   <= 1'b1;
                        wr_n_q   <= 1'b1;
                        eu_ack_q <= (owner_q != OWN_PF);
                        pf_ack_q <= (owner_q == OWN_PF);
                        err_q    <= ~bus_ready;
                        if (bus_ready && !we_q)
                            rdata_q <= bus_rdata;
                    end else begin
                        state_q <= S_TW;
                        if (state_q == S_TW)
                            wcnt_q <= wcnt_q + WCW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign eu_ack    = eu_ack_q;
    assign pf_ack    = pf_ack_q;
    assign bus_err   = err_q;
    assign bus_ale   = ale_q;
    assign bus_rd_n  = rd_n_q;
    assign bus_wr_n  = wr_n_q;
    assign busy      = busy_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_biu_bus_cycle_ctrl.sv
// Randomized scoreboard bench for biu_bus_cycle_ctrl with an
// address-driven memory responder and a cycle-level monitor.
module tb_biu_bus_cycle_ctrl;

    localparam int AW   = 20;
    localparam int DW   = 16;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          eu_req = 1'b0, eu_we = 1'b0;
    logic [AW-1:0] eu_addr = '0;
    logic [DW-1:0] eu_wdata = '0;
    logic          eu_ack;
    logic          pf_req = 1'b0;
    logic [AW-1:0] pf_addr = '0;
    logic          pf_ack;
    logic [DW-1:0] rdata;
    logic          bus_err;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_ale, bus_rd_n, bus_wr_n;
    logic          bus_ready = 1'b0;
    logic          busy;

    always #5 clk = ~clk;

    biu_bus_cycle_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .reset(reset),
        .eu_req(eu_req), .eu_we(eu_we), .eu_addr(eu_addr),
        .eu_wdata(eu_wdata), .eu_ack(eu_ack),
        .pf_req(pf_req), .pf_addr(pf_addr), .pf_ack(pf_ack),
        .rdata(rdata), .bus_err(bus_err),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ale(bus_ale),
        .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
        .bus_ready(bus_ready), .busy(busy)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t eu_q[$];
    txn_t pf_q[$];
    int   checks = 0;
    int   errors = 0;
    int   scnt = 0;

    // Memory model: wait states and read data are pure functions of address.
    function automatic int nwait(input logic [AW-1:0] a);
        return (int'(a[3:0]) + int'(a[11:8])) % (MAXW + 3);
    endfunction

    function automatic logic [DW-1:0] rdfn(input logic [AW-1:0] a);
        return a[15:0] ^ {a[19:16], 12'hA53};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Responder: counts strobe cycles, raises READY after nwait(addr) Tw.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!bus_rd_n || !bus_wr_n) scnt++;
            else scnt = 0;
            if (scnt >= 2) bus_ready = (scnt - 2 >= nwait(bus_addr));
            else bus_ready = 1'($urandom);
            bus_rdata = bus_ready ? rdfn(bus_addr) : DW'($urandom);
        end
    end

    int            cyc = 0, t_ale = 0, scyc = 0;
    bit            in_cyc = 0, own_exp = 0, skip = 1;
    bit            saw_rd = 0, saw_wr = 0;
    logic [AW-1:0] a_ale = '0;
    logic [DW-1:0] wd_ale = '0;
    logic [DW-1:0] last_rd = '0;
    bit            p_eu_req = 0, p_pf_req = 0;
    bit            p_eu_ack = 0, p_pf_ack = 0, p_busy = 0;

    task automatic check_ack();
        txn_t t;
        bit   have;
        int   w, ew;
        bit   er;
        logic [DW-1:0] exp_rd;
        chk("ack_onehot", 32'(eu_ack & pf_ack), 0);
        chk("ack_in_cycle", 32'(in_cyc), 1);
        chk("ack_owner", 32'(pf_ack), 32'(own_exp));
        chk("strobes_t4", {bus_rd_n, bus_wr_n}, 2'b11);
        have = pf_ack ? (pf_q.size() != 0) : (eu_q.size() != 0);
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack with no request pending at %0t", $time);
        end else begin
            t  = pf_ack ? pf_q.pop_front() : eu_q.pop_front();
            w  = nwait(t.addr);
            er = (w > MAXW);
            ew = er ? MAXW : w;
            chk("bus_addr", a_ale, t.addr);
            chk("write_strobe", 32'(saw_wr), 32'(t.we));
            chk("read_strobe", 32'(saw_rd), 32'(!t.we));
            if (t.we) chk("bus_wdata", wd_ale, t.wdata);
            chk("latency", cyc - t_ale, 3 + ew);
            chk("strobe_cycles", scyc, 2 + ew);
            chk("bus_err", 32'(bus_err), 32'(er));
            if (!t.we) begin
                exp_rd = er ? last_rd : rdfn(t.addr);
                chk("rdata", rdata, exp_rd);
                last_rd = exp_rd;
            end
        end
        in_cyc = 0;
    endtask

    // Monitor: arbitration rules re-derived from sampled requests each cycle.
    initial begin
        bit gp, eu_e, pf_e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                in_cyc  = 0;
                skip    = 1;
                last_rd = '0;
            end else if (skip) begin
                skip = 0;
            end else begin
                gp   = !p_busy || p_eu_ack || p_pf_ack;
                eu_e = p_eu_req && !p_eu_ack;
                pf_e = p_pf_req && !p_pf_ack;
                chk("ale", 32'(bus_ale), 32'(gp && (eu_e || pf_e)));
                chk("strobes_exclusive", 32'(!bus_rd_n && !bus_wr_n), 0);
                if (gp && (eu_e || pf_e)) begin
                    in_cyc  = 1;
                    own_exp = !eu_e;
                    t_ale   = cyc;
                    scyc    = 0;
                    saw_rd  = 0;
                    saw_wr  = 0;
                    a_ale   = bus_addr;
                    wd_ale  = bus_wdata;
                    chk("busy_t1", 32'(busy), 1);
                end
                if (in_cyc && (!bus_rd_n || !bus_wr_n)) begin
                    scyc++;
                    if (!bus_rd_n) saw_rd = 1;
                    if (!bus_wr_n) saw_wr = 1;
                end
                if (eu_ack || pf_ack) check_ack();
            end
            p_eu_req = eu_req;
            p_pf_req = pf_req;
            p_eu_ack = eu_ack;
            p_pf_ack = pf_ack;
            p_busy   = busy;
        end
    end

    task automatic run_req(input bit pf, input int n);
        txn_t t;
        int   to;
        bit   hold;
        hold = 0;
        for (int i = 0; i < n; i++) begin
            if (!hold) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            t.addr  = AW'($urandom);
            t.we    = pf ? 1'b0 : 1'($urandom);
            t.wdata = DW'($urandom);
            if (pf) begin
                pf_q.push_back(t);
                pf_addr = t.addr;
                pf_req  = 1'b1;
            end else begin
                eu_q.push_back(t);
                eu_addr  = t.addr;
                eu_we    = t.we;
                eu_wdata = t.wdata;
                eu_req   = 1'b1;
            end
            to = 0;
            do begin
                @(posedge clk);
                #1;
                to++;
            end while (!(pf ? pf_ack : eu_ack) && to < 300);
            if (to >= 300) begin
                checks++;
                errors++;
                $display("FAIL ack_timeout: requester %0d got no ack in 300 cycles", pf);
            end
            hold = 1'($urandom);
            if (!hold) begin
                if (pf) pf_req = 1'b0;
                else eu_req = 1'b0;
            end
        end
        if (pf) pf_req = 1'b0;
        else eu_req = 1'b0;
    endtask

    initial begin
        txn_t t;
        int   to;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_eu_ack", 32'(eu_ack), 0);
        chk("rst_pf_ack", 32'(pf_ack), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_ale", 32'(bus_ale), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", {bus_rd_n, bus_wr_n}, 2'b11);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_rdata", rdata, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        fork
            run_req(1'b0, 60);
            run_req(1'b1, 60);
        join
        repeat (5) begin
            @(posedge clk);
            #1;
        end

        // Reset asserted while a read sits in its first Tw.
        do begin
            t.addr = AW'($urandom);
        end while (nwait(t.addr) < 2 || nwait(t.addr) > MAXW);
        t.we    = 1'b0;
        t.wdata = '0;
        eu_q.push_back(t);
        eu_addr = t.addr;
        eu_we   = 1'b0;
        eu_req  = 1'b1;
        to = 0;
        do begin
            @(posedge clk);
            #2;
            to++;
        end while (scnt < 3 && to < 50);
        if (to >= 50) begin
            checks++;
            errors++;
            $display("FAIL reach_tw: read never entered Tw");
        end
        reset = 1'b1;
        #1;
        chk("midrst_rd_n", 32'(bus_rd_n), 1);
        chk("midrst_wr_n", 32'(bus_wr_n), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_eu_ack", 32'(eu_ack), 0);
        chk("midrst_pf_ack", 32'(pf_ack), 0);
        eu_q.delete();
        eu_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_req(1'b0, 3);
        run_req(1'b1, 2);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("eu_queue_drained", eu_q.size(), 0);
        chk("pf_queue_drained", pf_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
